// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared constants for the memory responder (state codes, defaults, physical address width)
package mem_resp_pkg;
   localparam int PA_W = 20;
   localparam int AW_DEF = 12;
   localparam logic [PA_W-1:0] BASE_DEF = 20'h12000;
   localparam int WAIT_DEF = 2;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_LO = 3'd1;
   localparam logic [2:0] S_XFER_LO = 3'd2;
   localparam logic [2:0] S_WAIT_HI = 3'd3;
   localparam logic [2:0] S_XFER_HI = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: even/odd byte lanes sharing one row index; sync write per lane, combinational read
// ports: clk, idx (row = byte address >> 1), we_even/we_odd, wd_even/wd_odd, rd_even/rd_odd
module mem_byte_array #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic [AW-2:0] idx,
   input  logic          we_even,
   input  logic          we_odd,
   input  logic [7:0]    wd_even,
   input  logic [7:0]    wd_odd,
   output logic [7:0]    rd_even,
   output logic [7:0]    rd_odd
);
   logic [7:0] lane_even [2**(AW-1)];
   logic [7:0] lane_odd  [2**(AW-1)];
   always_ff @(posedge clk) begin
      if (we_even) lane_even[idx] <= wd_even;
      if (we_odd) lane_odd[idx] <= wd_odd;
   end
   assign rd_even = lane_even[idx];
   assign rd_odd  = lane_odd[idx];
endmodule

// File: rtl/mem_resp_bus.sv
// mem_resp_bus: windowed byte/word memory responder with wait states and split unaligned words
// ports: CLK, RST (async high), REQ/WE/WORD/DIR/WDATA request, BUSY/ACK/ERR/RDATA response
module mem_resp_bus
   import mem_resp_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter logic [PA_W-1:0] BASE = BASE_DEF,
   parameter int WAIT = WAIT_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ,
   input  logic            WE,
   input  logic            WORD,
   input  logic [PA_W-1:0] DIR,
   input  logic [15:0]     WDATA,
   output logic            BUSY,
   output logic            ACK,
   output logic            ERR,
   output logic [15:0]     RDATA
);
   localparam logic [2:0] LO_ENTRY = (WAIT == 0) ? S_XFER_LO : S_WAIT_LO;
   localparam logic [2:0] HI_ENTRY = (WAIT == 0) ? S_XFER_HI : S_WAIT_HI;
   localparam logic [3:0] WLOAD = 4'((WAIT == 0) ? 0 : WAIT - 1);
   logic [2:0]    state;
   logic [3:0]    cnt;
   logic          we_r, word_r, err_r;
   logic [AW-1:0] addr_r;
   logic [15:0]   wdata_r;
   logic [7:0]    lo_r;
   logic          hit, accept, hi_phase, xfer, full, split;
   logic [AW-1:0] paddr;
   logic [7:0]    bdata, brd, rd_even, rd_odd;
   assign BUSY = state != S_IDLE && state != S_DONE;
   assign ACK = state == S_DONE;
   assign ERR = ACK && err_r;
   assign hit = DIR[PA_W-1:AW] == BASE[PA_W-1:AW];
   assign accept = REQ && !BUSY;
   assign hi_phase = state == S_XFER_HI;
   assign xfer = state == S_XFER_LO || hi_phase;
   // aligned word moves both lanes in the single low phase
   assign full = word_r && !addr_r[0] && !hi_phase;
   assign split = word_r && addr_r[0];
   // high byte of a split word wraps inside the window
   assign paddr = addr_r + AW'(hi_phase);
   assign bdata = hi_phase ? wdata_r[15:8] : wdata_r[7:0];
   assign brd = paddr[0] ? rd_odd : rd_even;
   mem_byte_array #(.AW(AW)) u_array (
      .clk     (CLK),
      .idx     (paddr[AW-1:1]),
      .we_even (xfer && we_r && (full || !paddr[0])),
      .we_odd  (xfer && we_r && (full || paddr[0])),
      .wd_even (bdata),
      .wd_odd  (full ? wdata_r[15:8] : bdata),
      .rd_even (rd_even),
      .rd_odd  (rd_odd)
   );
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         cnt <= '0;
         we_r <= 1'b0;
         word_r <= 1'b0;
         err_r <= 1'b0;
         addr_r <= '0;
         wdata_r <= '0;
         lo_r <= '0;
         RDATA <= '0;
      end else if (accept) begin
         we_r <= WE;
         word_r <= WORD;
         addr_r <= DIR[AW-1:0];
         wdata_r <= WDATA;
         err_r <= !hit;
         cnt <= WLOAD;
         state <= hit ? LO_ENTRY : S_DONE;
         if (!hit && !WE) RDATA <= '0;
      end else if (state == S_DONE) begin
         state <= S_IDLE;
      end else if (state == S_WAIT_LO || state == S_WAIT_HI) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd0) state <= (state == S_WAIT_LO) ? S_XFER_LO : S_XFER_HI;
      end else if (state == S_XFER_LO) begin
         lo_r <= brd;
         if (split) begin
            state <= HI_ENTRY;
            cnt <= WLOAD;
         end else begin
            state <= S_DONE;
            if (!we_r) RDATA <= word_r ? {rd_odd, rd_even} : {8'h00, brd};
         end
      end else if (state == S_XFER_HI) begin
         state <= S_DONE;
         if (!we_r) RDATA <= {brd, lo_r};
      end
   end
endmodule

// File: tb/tb_mem_resp_bus.sv
// tb_mem_resp_bus: directed checks of mem_resp_bus (WAIT=2 instance plus a WAIT=0 instance)
module tb_mem_resp_bus;
   logic        CLK = 1'b0, RST = 1'b1, REQ = 1'b0, REQ0 = 1'b0, WE = 1'b0, WORD = 1'b0;
   logic [19:0] DIR = '0;
   logic [15:0] WDATA = '0;
   logic        BUSY, ACK, ERR, BUSY0, ACK0, ERR0;
   logic [15:0] RDATA, RDATA0;
   int          checks = 0, failures = 0;
   int          lat;
   logic        err;
   logic [15:0] rd;

   always #5 CLK = ~CLK;

   mem_resp_bus #(.WAIT(2)) u_dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .WORD(WORD), .DIR(DIR), .WDATA(WDATA),
      .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA)
   );
   mem_resp_bus #(.WAIT(0)) u_dut0 (
      .CLK(CLK), .RST(RST), .REQ(REQ0), .WE(WE), .WORD(WORD), .DIR(DIR), .WDATA(WDATA),
      .BUSY(BUSY0), .ACK(ACK0), .ERR(ERR0), .RDATA(RDATA0)
   );

   // one request; lat = edges from accept to ACK (0 on timeout)
   task automatic xact(input bit sel, input bit we, input bit word, input logic [19:0] dir,
                       input logic [15:0] wd, output int l, output logic e, output logic [15:0] r);
      int n;
      @(negedge CLK);
      WE = we; WORD = word; DIR = dir; WDATA = wd;
      if (sel) REQ0 = 1'b1; else REQ = 1'b1;
      @(posedge CLK); #1;
      REQ = 1'b0; REQ0 = 1'b0;
      n = 1;
      while (n <= 40 && (sel ? ACK0 : ACK) !== 1'b1) begin
         @(posedge CLK); #1;
         n++;
      end
      l = (n <= 40) ? n : 0;
      e = sel ? ERR0 : ERR;
      r = sel ? RDATA0 : RDATA;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ACK); end
      checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", ERR); end
      checks++; if (RDATA !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", RDATA); end
      checks++; if (RDATA0 !== 16'h0000) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0000", RDATA0); end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_aligned;
      xact(0, 1, 1, 20'h12340, 16'hBEEF, lat, err, rd);
      checks++; if (lat !== 4) begin failures++; $display("FAIL aligned_wr_lat got=%0d exp=4", lat); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL aligned_wr_err got=%b exp=0", err); end
      xact(0, 0, 1, 20'h12340, 16'h0000, lat, err, rd);
      checks++; if (lat !== 4) begin failures++; $display("FAIL aligned_rd_lat got=%0d exp=4", lat); end
      checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL aligned_rd_data got=%h exp=beef", rd); end
   endtask

   task automatic test_byte_merge;
      xact(0, 1, 0, 20'h12341, 16'hAA77, lat, err, rd);
      checks++; if (lat !== 4) begin failures++; $display("FAIL byte_wr_lat got=%0d exp=4", lat); end
      xact(0, 0, 1, 20'h12340, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h77EF) begin failures++; $display("FAIL merge_word_rd got=%h exp=77ef", rd); end
      xact(0, 0, 0, 20'h12341, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h0077) begin failures++; $display("FAIL merge_byte_rd got=%h exp=0077", rd); end
      checks++; if (lat !== 4) begin failures++; $display("FAIL byte_rd_lat got=%0d exp=4", lat); end
   endtask

   task automatic test_unaligned;
      xact(0, 1, 1, 20'h12FFF, 16'hA55A, lat, err, rd);
      checks++; if (lat !== 7) begin failures++; $display("FAIL unal_wr_lat got=%0d exp=7", lat); end
      xact(0, 0, 0, 20'h12FFF, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h005A) begin failures++; $display("FAIL unal_lo_byte got=%h exp=005a", rd); end
      xact(0, 0, 0, 20'h12000, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h00A5) begin failures++; $display("FAIL unal_wrap_byte got=%h exp=00a5", rd); end
      xact(0, 0, 1, 20'h12FFF, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'hA55A) begin failures++; $display("FAIL unal_word_rd got=%h exp=a55a", rd); end
      checks++; if (lat !== 7) begin failures++; $display("FAIL unal_rd_lat got=%0d exp=7", lat); end
   endtask

   task automatic test_miss;
      xact(0, 0, 1, 20'h30000, 16'h0000, lat, err, rd);
      checks++; if (lat !== 1) begin failures++; $display("FAIL miss_rd_lat got=%0d exp=1", lat); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL miss_rd_err got=%b exp=1", err); end
      checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL miss_rd_data got=%h exp=0000", rd); end
      xact(0, 0, 1, 20'h12340, 16'h0000, lat, err, rd);
      xact(0, 1, 1, 20'h30000, 16'h1111, lat, err, rd);
      checks++; if (lat !== 1) begin failures++; $display("FAIL miss_wr_lat got=%0d exp=1", lat); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL miss_wr_err got=%b exp=1", err); end
      checks++; if (rd !== 16'h77EF) begin failures++; $display("FAIL miss_wr_rdata_held got=%h exp=77ef", rd); end
      xact(0, 0, 0, 20'h12000, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h00A5) begin failures++; $display("FAIL miss_wr_idx0 got=%h exp=00a5", rd); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL hit_err got=%b exp=0", err); end
      xact(0, 0, 1, 20'h12340, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h77EF) begin failures++; $display("FAIL miss_wr_recheck got=%h exp=77ef", rd); end
   endtask

   task automatic test_back_to_back;
      int n, extra;
      @(negedge CLK);
      WE = 1'b1; WORD = 1'b1; DIR = 20'h12200; WDATA = 16'hC0DE; REQ = 1'b1;
      @(posedge CLK); #1;
      WE = 1'b0; WDATA = 16'hFFFF;
      n = 1;
      while (n <= 20 && ACK !== 1'b1) begin @(posedge CLK); #1; n++; end
      checks++; if (n !== 4) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=4", n); end
      @(posedge CLK); #1;
      REQ = 1'b0;
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_accept_at_done got=%b exp=1", BUSY); end
      n = 1;
      while (n <= 20 && ACK !== 1'b1) begin
         if (n == 2) begin REQ = 1'b1; WE = 1'b1; end
         if (n == 3) REQ = 1'b0;
         @(posedge CLK); #1;
         n++;
      end
      checks++; if (n !== 4) begin failures++; $display("FAIL b2b_second_lat got=%0d exp=4", n); end
      checks++; if (RDATA !== 16'hC0DE) begin failures++; $display("FAIL b2b_second_data got=%h exp=c0de", RDATA); end
      extra = 0;
      repeat (6) begin @(posedge CLK); #1; if (ACK === 1'b1 || BUSY === 1'b1) extra++; end
      checks++; if (extra !== 0) begin failures++; $display("FAIL busy_req_ignored got=%0d exp=0", extra); end
      xact(0, 0, 1, 20'h12200, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'hC0DE) begin failures++; $display("FAIL busy_req_no_write got=%h exp=c0de", rd); end
   endtask

   task automatic test_wait0;
      xact(1, 1, 1, 20'h12340, 16'hBEEF, lat, err, rd);
      checks++; if (lat !== 2) begin failures++; $display("FAIL w0_wr_lat got=%0d exp=2", lat); end
      xact(1, 0, 1, 20'h12340, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL w0_rd_data got=%h exp=beef", rd); end
      xact(1, 1, 1, 20'h12001, 16'h1357, lat, err, rd);
      checks++; if (lat !== 3) begin failures++; $display("FAIL w0_unal_lat got=%0d exp=3", lat); end
      xact(1, 0, 1, 20'h12001, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h1357) begin failures++; $display("FAIL w0_unal_data got=%h exp=1357", rd); end
   endtask

   task automatic test_reset_mid;
      int extra;
      xact(0, 1, 0, 20'h12102, 16'h00C3, lat, err, rd);
      xact(0, 0, 0, 20'h12102, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h00C3) begin failures++; $display("FAIL rmid_prep got=%h exp=00c3", rd); end
      @(negedge CLK);
      WE = 1'b1; WORD = 1'b1; DIR = 20'h12101; WDATA = 16'h1234; REQ = 1'b1;
      @(posedge CLK); #1;
      REQ = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", BUSY); end
      checks++; if (ACK !== 1'b0) begin failures++; $display("FAIL rmid_ack got=%b exp=0", ACK); end
      checks++; if (RDATA !== 16'h0000) begin failures++; $display("FAIL rmid_rdata got=%h exp=0000", RDATA); end
      @(negedge CLK);
      RST = 1'b0;
      extra = 0;
      repeat (8) begin @(posedge CLK); #1; if (ACK === 1'b1) extra++; end
      checks++; if (extra !== 0) begin failures++; $display("FAIL rmid_no_ack got=%0d exp=0", extra); end
      xact(0, 0, 0, 20'h12101, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h0034) begin failures++; $display("FAIL rmid_lo_kept got=%h exp=0034", rd); end
      xact(0, 0, 0, 20'h12102, 16'h0000, lat, err, rd);
      checks++; if (rd !== 16'h00C3) begin failures++; $display("FAIL rmid_hi_old got=%h exp=00c3", rd); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_byte_merge();
      test_unaligned();
      test_miss();
      test_back_to_back();
      test_wait0();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_resp_bus.md
Name: mem_resp_bus

Overview:
- Memory-side responder for the 20-bit physical addresses produced by the address-generation logic.
- Accepts byte or word read/write requests and decodes a window select.
- Applies a programmable number of wait states, then answers with a one-cycle ACK.
- Splits odd-address word accesses into two byte phases (low byte, then high byte), 8086-style.

Parameters:
- AW, 12, byte-address bits of the internal array. Array size is 2^AW bytes.
- BASE, 20'h12000, window base. Only DIR[19:AW] is compared; BASE[AW-1:0] must be 0.
- WAIT, 2, wait cycles inserted before each byte/word phase. Range 0..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  1  request strobe. Sampled only when BUSY=0.
- WE  in  1  1=write, 0=read.
- WORD  in  1  1=16-bit access, 0=byte access.
- DIR  in  20  physical byte address.
- WDATA  in  16  write data. Byte writes use [7:0].
- BUSY  out  1  request in progress; new REQ is ignored.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  valid with ACK; 1 = address outside the window.
- RDATA  out  16  read data. Updated only on a read ACK; held otherwise.

Behaviour:
- Reset:
  - BUSY=0, ACK=0, ERR=0, RDATA=16'h0000, FSM=IDLE.
  - Array contents are not reset and are undefined at power-up.
- Accept:
  - At edge k with REQ=1 and BUSY=0, latch WE, WORD, DIR and WDATA.
  - BUSY=1 from k. Inputs after k are don't-care.
- Window check at accept:
  - Hit when DIR[19:AW]==BASE[19:AW].
  - Miss: go to DONE directly. ACK=1, ERR=1 at cycle k+1. No array write. RDATA unchanged on a miss-write; forced to 0 on a miss-read.
- States:
  - IDLE
  - WAIT_LO: counts WAIT cycles.
  - XFER_LO
  - WAIT_HI: counts WAIT cycles.
  - XFER_HI
  - DONE: ACK=1, BUSY=0.
- Transitions:
  - IDLE→WAIT_LO, or →XFER_LO if WAIT=0.
  - XFER_LO→DONE for a byte access or an aligned word (DIR[0]=0).
  - XFER_LO→WAIT_HI/XFER_HI for an unaligned word (DIR[0]=1).
  - XFER_HI→DONE.
  - DONE→IDLE, or accepts a new REQ in the same cycle. Back-to-back requests allowed.
- Latency, measured as the ACK cycle after accept at edge k:
  - Hit, byte or aligned word: k+WAIT+2.
  - Unaligned word: k+2*WAIT+3.
  - Miss: k+1.
- Addressing:
  - Array index is DIR[AW-1:0].
  - Aligned word: low byte at index a, high byte at a+1, in a single XFER_LO.
  - Unaligned high byte: index (a+1) mod 2^AW. It wraps to the window base and never leaves the window.
- Data:
  - Byte read returns RDATA={8'h00, byte}.
  - Word read returns {hi, lo}.
  - Writes take effect at the end of the XFER cycle of their phase.
- REQ while BUSY=1: ignored, not queued.
- Reset mid-operation:
  - Immediate abort. No ACK.
  - Bytes already written in a completed XFER_LO remain.
  - Outputs take their reset values.

Decomposition:
- Shared package (mem_resp_pkg):
  - FSM state encoding (3-bit localparams).
  - Default AW, BASE and WAIT.
  - 20-bit address width constant, reusable by the address-generation side.
- Sub-module mem_byte_array:
  - Two byte lanes (even/odd index).
  - Synchronous write with per-lane enable; combinational read.
  - Lets an aligned word use both lanes in one cycle.
- FSM, wait counter, window decode and unaligned sequencing stay in mem_resp_bus.

Test Plan:
- Aligned write/read, WAIT=2: write word 16'hBEEF at 20'h12340, accepted at k → ACK at k+4, ERR=0. Read word 20'h12340 → RDATA=16'hBEEF.
- Byte merge: byte write 8'h77 at 20'h12341, then word read 20'h12340 → 16'h77EF. Byte read 20'h12341 → 16'h0077.
- Unaligned wrap: word write 16'hA55A at 20'h12FFF → ACK at k+7. Byte read 20'h12FFF → 16'h005A; byte read 20'h12000 → 16'h00A5. Word read 20'h12FFF → 16'hA55A.
- Window miss: word read at 20'h30000 → ACK=ERR=1 at k+1, RDATA=0. Write at 20'h30000 leaves the array unchanged (recheck 20'h12340).
- Handshake: hold REQ=1 continuously with two queued requests. The second is accepted exactly at the DONE edge, and REQ pulses during BUSY are ignored. With WAIT=0, aligned ACK at k+2.
- Reset mid-operation: unaligned write 16'h1234 at 20'h12101, assert RST during WAIT_HI → no ACK, BUSY=0, RDATA=0. Afterwards byte 20'h12101=8'h34, and 20'h12102 keeps its old value.
